// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a registered one-hot grant that feeds an 8-to-3 encoder.
// Define ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD consecutive cycles of ownership.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       grant_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [2:0] last_ptr;
    logic [2:0] owner;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be >= 1");
    end

    // Nearest set bit after ptr wins; the bit at ptr itself is considered last.
    function automatic logic [7:0] pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [2:0] idx;
        pick = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = ptr + 3'(k);
            if (r[idx]) pick = 8'b1 << idx;
        end
    endfunction

    always_comb begin
        // NOTE: default assignment first so the loop never leaves owner unassigned (no latch).
        owner = '0;
        for (int i = 0; i < 8; i++) begin
            if (grant[i]) owner = 3'(i);
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             others;

    assign others = |(req & ~grant);
`endif

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so it
    // clears a live grant without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            last_ptr    <= 3'd7;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant       <= pick(req, last_ptr);
                        grant_valid <= 1'b1;
                        state       <= BUSY;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (req[owner]) begin
`ifdef ARB_HOLD_LIMIT_EN
                        // Saturated counter keeps the rotation armed for a waiting requester.
                        if (hold_cnt >= HOLD_LAST && others) begin
                            last_ptr <= owner;
                            grant    <= pick(req, owner);
                            hold_cnt <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
`endif
                    end else if (|req) begin
                        last_ptr <= owner;
                        grant    <= pick(req, owner);
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        last_ptr    <= owner;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter; the registered one-hot stage directly upstream of the 8-to-3 encoder.
- grant[7:0] drives the encoder data input and grant_valid drives its active-high enable, so the encoder yields the binary index of the current owner.
- Guarantees grant is always zero or exactly one-hot, which the encoder requires.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others wait; legal range >= 1; used only with ARB_HOLD_LIMIT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; bit i = requester i; level-sensitive.
- grant  output  8  registered one-hot grant; 8'b0 when no owner.
- grant_valid  output  1  registered; equals |grant at all times.

Behaviour:
- Reset (async, active-high):
  - grant=8'b0, grant_valid=0, state=IDLE, last_ptr=3'd7, hold_cnt=0.
  - Takes effect immediately, including mid-grant, independent of clk.
- State IDLE:
  - At each edge, if req!=0: grant the first set bit searching last_ptr+1, +2, ... wrapping mod 8.
  - Load grant and set grant_valid; go to BUSY; hold_cnt=0.
  - If req==0, stay IDLE with outputs 0.
- Latency: 1 clock from req sampled to grant visible. No combinational path from req to grant.
- State BUSY (owner = index of set grant bit):
  - req[owner]=1 (no forced rotation): hold grant; hold_cnt saturates at MAX_HOLD.
  - req[owner]=0 and other bits set: last_ptr=owner, then next grant = first set bit searching owner+1, wrapping. Back-to-back, no idle bubble; stay BUSY; hold_cnt=0.
  - req[owner]=0 and req==0: last_ptr=owner, grant=0, grant_valid=0, go IDLE.
- Search rule: wrap 7->0. The owner's own bit is considered last, so a re-request by the releasing owner is served only if no one else requests.
- Simultaneous release and new requests are resolved in the same edge per the rules above.
- Requests asserted and dropped between edges are not seen.
- A grant is never withdrawn while its request is high, except by reset or the optional hold limit.
- Invariant checked every cycle: grant_valid == |grant, and $onehot0(grant).
- Counter width: $clog2(MAX_HOLD+1) bits.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - In BUSY with req[owner]=1, hold_cnt increments each edge.
  - When hold_cnt==MAX_HOLD-1 and any other req bit is set, the next edge forces rotation: last_ptr=owner, grant = next requester after owner, hold_cnt=0.
  - If owner is the sole requester, it keeps the grant and hold_cnt stays saturated; rotation happens at the first edge another request appears.
- Undefined:
  - hold_cnt logic is absent; an owner holds indefinitely while its req stays high.
  - MAX_HOLD is ignored.

Test Plan:
- Reset: req=8'hFF held during rst -> grant=0, grant_valid=0. First edge after release -> grant=8'b00000001, valid=1.
- Single requester: req=8'b00100000 for 5 cycles -> grant=8'b00100000 from cycle 1 to cycle 5. Drop req -> next edge grant=0, valid=0, IDLE.
- Rotation: req=8'hFF, current owner's bit deasserted for one cycle after each grant -> grant sequence 01,02,04,08,10,20,40,80,01, with no idle cycle between owners.
- Wrap/fairness: owner bit6 releases while req=8'b11000001 -> grant 8'b10000000. Bit7 releases -> 8'b00000001. Bit6 is served after bit0 releases.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=4): req=8'b00000011 constant -> grant 01 for 4 cycles, 02 for 4, 01 for 4, repeating. Macro undefined: grant stays 01 forever.
- Async reset mid-grant: owner 8'b00001000, rst pulsed between edges -> grant=0 and valid=0 immediately. After release with req=8'b00001001 -> grant=8'b00000001 (last_ptr back to 7).
